// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared definitions for the program loader and the CPU:
//               frame sync byte, loader state encoding and the instruction
//               field layout also used by the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // First byte of every program image frame.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Loader frame parser states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CNT_HI  = 3'd1,
    ST_CNT_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CHECK   = 3'd5
  } loader_state_e;

  // Instruction word layout: opcode in [15:12], then three register/immediate
  // nibbles.
  localparam int unsigned c_opcode_msb = 15;
  localparam int unsigned c_opcode_lsb = 12;
  localparam int unsigned c_nib_a_lsb  = 8;
  localparam int unsigned c_nib_b_lsb  = 4;
  localparam int unsigned c_nib_c_lsb  = 0;

  function automatic logic [3:0] insn_opcode(input logic [15:0] insn);
    return insn[c_opcode_msb:c_opcode_lsb];
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_timeout.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_timeout
// Description : Idle-cycle counter for the loader. Counts cycles while
//               enabled and no transfer occurs; clears on every transfer or
//               when disabled. expire_o is high in the idle cycle whose edge
//               makes the count reach TIMEOUT_CYCLES.
// Ports       : clk, reset (async, active-low), enable_i, clear_i, expire_o
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire_o = enable_i && !clear_i &&
                    (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i || clear_i || expire_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream program loader. Parses SYNC/COUNT/words/CHECKSUM
//               frames, writes big-endian 16-bit words to instruction memory
//               from address 0, and holds the CPU in reset until a
//               checksum-verified image is loaded.
// Ports       : clk, reset (async, active-low)
//               byte_data/byte_valid/byte_ready  - input byte stream
//               imem_wr_enable/address/data       - imem write port
//               cpu_hold, load_done, load_error   - load status
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_wr_enable,
  output logic [ADDR_WIDTH-1:0] imem_wr_address,
  output logic [15:0]           imem_wr_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

  loader_state_e         state_q, state_d;
  logic [7:0]            cnt_hi_q, cnt_hi_d;
  logic [7:0]            hi_q, hi_d;
  logic [7:0]            csum_q, csum_d;
  logic [15:0]           left_q, left_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  xfer;
  logic                  expire;
  logic [15:0]           frame_len;

  // No backpressure: ready simply follows the reset release.
  assign byte_ready = reset;
  assign xfer       = byte_valid && byte_ready;
  assign frame_len  = {cnt_hi_q, byte_data};

  imem_loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .enable_i (state_q != ST_IDLE),
    .clear_i  (xfer),
    .expire_o (expire)
  );

  always_comb begin
    state_d   = state_q;
    cnt_hi_d  = cnt_hi_q;
    hi_d      = hi_q;
    csum_d    = csum_q;
    left_d    = left_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer && byte_data == SYNC_BYTE) begin
          state_d = ST_CNT_HI;
          done_d  = 1'b0;
          err_d   = 1'b0;
          csum_d  = 8'h00;
          hold_d  = 1'b1;
          idx_d   = '0;
        end
      end
      ST_CNT_HI: begin
        if (xfer) begin
          cnt_hi_d = byte_data;
          csum_d   = csum_q ^ byte_data;
          state_d  = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (xfer) begin
          csum_d = csum_q ^ byte_data;
          // Images larger than the address space are rejected up front.
          if ({17'd0, frame_len} > (33'd1 << ADDR_WIDTH)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (frame_len == 16'd0) begin
            state_d = ST_CHECK;
          end else begin
            left_d  = frame_len;
            state_d = ST_DATA_HI;
          end
        end
      end
      ST_DATA_HI: begin
        if (xfer) begin
          hi_d    = byte_data;
          csum_d  = csum_q ^ byte_data;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (xfer) begin
          csum_d    = csum_q ^ byte_data;
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = {hi_q, byte_data};
          idx_d     = idx_q + c_addr_one;
          left_d    = left_q - 16'd1;
          state_d   = (left_q == 16'd1) ? ST_CHECK : ST_DATA_HI;
        end
      end
      ST_CHECK: begin
        if (xfer) begin
          if (byte_data == csum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d  = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Expiry only fires on cycles without a transfer, so it never collides
    // with the per-state updates above.
    if (expire) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_hi_q  <= 8'h00;
      hi_q      <= 8'h00;
      csum_q    <= 8'h00;
      left_q    <= 16'd0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 16'h0000;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_hi_q  <= cnt_hi_d;
      hi_q      <= hi_d;
      csum_q    <= csum_d;
      left_q    <= left_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign imem_wr_enable  = wr_en_q;
  assign imem_wr_address = wr_addr_q;
  assign imem_wr_data    = wr_data_q;
  assign cpu_hold        = hold_q;
  assign load_done       = done_q;
  assign load_error      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Stimulus pushes the
//               expected memory writes into a queue; a monitor pops and
//               compares each write strobe. Status outputs are compared
//               against hand-computed values after each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int AW = 16;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          imem_wr_enable;
  logic [AW-1:0] imem_wr_address;
  logic [15:0]   imem_wr_data;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [7:0]  frm[$];

  imem_loader #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .byte_data       (byte_data),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .imem_wr_enable  (imem_wr_enable),
    .imem_wr_address (imem_wr_address),
    .imem_wr_data    (imem_wr_data),
    .cpu_hold        (cpu_hold),
    .load_done       (load_done),
    .load_error      (load_error)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_wr_enable) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                 imem_wr_address, imem_wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({imem_wr_address, imem_wr_data} !== mon_exp) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   imem_wr_address, imem_wr_data, mon_exp[31:16], mon_exp[15:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_status(input string name, input logic done,
                              input logic err, input logic hold);
    check({name, "_done"}, {31'd0, load_done}, {31'd0, done});
    check({name, "_error"}, {31'd0, load_error}, {31'd0, err});
    check({name, "_hold"}, {31'd0, cpu_hold}, {31'd0, hold});
  endtask

  task automatic check_drained(input string name);
    check({name, "_writes_pending"}, exp_q.size(), 32'd0);
  endtask

  // One byte per cycle; returns #1 after the transfer edge.
  task automatic send(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_frame();
    while (frm.size() > 0) send(frm.pop_front());
  endtask

  task automatic push_good();
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0001, 16'hABCD});
    frm = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check({name, "_wren"}, {31'd0, imem_wr_enable}, 32'd0);
    check({name, "_addr"}, {16'd0, imem_wr_address}, 32'd0);
    check({name, "_data"}, {16'd0, imem_wr_data}, 32'd0);
    check_status(name, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", {31'd0, byte_ready}, 32'd1);

    // Good frame.
    push_good();
    send_frame();
    check_status("good", 1'b1, 1'b0, 1'b0);
    check_drained("good");

    // Bad checksum: both writes still land.
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0001, 16'hABCD});
    frm = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    send_frame();
    check_status("badsum", 1'b0, 1'b1, 1'b1);
    check_drained("badsum");

    // Leading noise then zero-length image.
    frm = '{8'h11, 8'h22, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame();
    check_status("zerolen", 1'b1, 1'b0, 1'b0);

    // Timeout after one high byte; boundary one cycle before expiry.
    frm = '{8'hA5, 8'h00, 8'h01, 8'h12};
    send_frame();
    repeat (TO - 1) @(posedge clk);
    #1;
    check_status("timeout_early", 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_status("timeout", 1'b0, 1'b1, 1'b1);
    check_drained("timeout");
    send(8'h00);
    push_good();
    send_frame();
    check_status("after_timeout", 1'b1, 1'b0, 1'b0);
    check_drained("after_timeout");

    // 0xA5 inside a frame is plain data: cs = 00^01^A5^5A = FE.
    exp_q.push_back({16'h0000, 16'hA55A});
    frm = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'h5A, 8'hFE};
    send_frame();
    check_status("sync_as_data", 1'b1, 1'b0, 1'b0);
    check_drained("sync_as_data");

    // Mid-frame reset after the first word.
    exp_q.push_back({16'h0000, 16'h1234});
    frm = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_frame();
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(posedge clk);
    #1;
    check_drained("midreset");
    reset = 1'b1;
    @(posedge clk);
    #1;
    push_good();
    send_frame();
    check_status("after_midreset", 1'b1, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check_drained("final");
    summary();
    $finish;
  end

endmodule
`default_nettype wire
